// File: rtl/rom_arb_pkg.sv
// Shared encodings and the address legality check for the ROM port arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package rom_arb_pkg;

   // Load size encodings as they appear on d_size; 3 is reserved and always illegal.
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // Who the ROM word arriving next cycle belongs to.
   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_DATA  = 2'd2
   } owner_e;

   // Everything the response cycle needs to know about the granted request.
   typedef struct packed {
      logic       err;
      logic [1:0] off;
      logic [1:0] size;
      logic       uns;
   } rsp_ctx_t;

   // A request is legal when aligned for its size and its address lies in
   // [rom_start, rom_start+rom_size-4]. The compare is done in 33 bits so an
   // address below rom_start can never wrap around into the window.
   function automatic logic addr_ok(input logic [31:0] addr,
                                    input logic [1:0]  size,
                                    input logic [31:0] rom_start,
                                    input logic [31:0] rom_size);
      logic [32:0] a;
      logic [32:0] lo;
      logic [32:0] hi;
      logic        aligned;
      a  = {1'b0, addr};
      lo = {1'b0, rom_start};
      hi = lo + {1'b0, rom_size} - 33'd4;
      case (size)
         SZ_BYTE: aligned = 1'b1;
         SZ_HALF: aligned = ~addr[0];
         SZ_WORD: aligned = (addr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
      return aligned && (a >= lo) && (a <= hi);
   endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Fetch and load request/response ports shared between the core and the ROM arbiter.
// Latency: n/a (signal bundle); responses arrive one cycle after gnt.
// Backpressure: a requester whose gnt is low keeps req/addr/size stable.
interface rom_port_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        i_err;

   logic        d_req;
   logic [31:0] d_addr;
   logic [1:0]  d_size;
   logic        d_unsigned;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;

   // Core side: issues requests, consumes grants and responses.
   modport master (
      output i_req, i_addr, d_req, d_addr, d_size, d_unsigned,
      input  i_gnt, i_rvalid, i_rdata, i_err,
      input  d_gnt, d_rvalid, d_rdata, d_err
   );

   // Arbiter side: consumes requests, produces grants and responses.
   modport slave (
      input  i_req, i_addr, d_req, d_addr, d_size, d_unsigned,
      output i_gnt, i_rvalid, i_rdata, i_err,
      output d_gnt, d_rvalid, d_rdata, d_err
   );
endinterface

// File: rtl/rom_load_align.sv
// Extracts a byte/half/word from a little-endian ROM word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
module rom_load_align
   import rom_arb_pkg::*;
(
   input  logic [31:0] rom_q,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] rdata
);
   logic [15:0] lane;

   // Shift the addressed byte down to bit 0, then extend according to size.
   always_comb begin
      lane  = 16'(rom_q >> {offset, 3'b000});
      rdata = '0;
      case (size)
         SZ_BYTE: rdata = {{24{~is_unsigned & lane[7]}},  lane[7:0]};
         SZ_HALF: rdata = {{16{~is_unsigned & lane[15]}}, lane[15:0]};
         SZ_WORD: rdata = rom_q;
         default: rdata = '0;
      endcase
   end
endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one single-port synchronous ROM between instruction fetch and data load.
// Latency: grant is combinational; response is exactly one cycle after grant.
// Backpressure: losing port sees gnt low and holds its request; one read per cycle.
module rom_port_arbiter
   import rom_arb_pkg::*;
#(
   parameter int          ROM_SIZE     = 20480,
   parameter logic [31:0] ROM_START    = 32'h0,
   parameter int          ROM_AW       = 13,
   parameter int          STARVE_LIMIT = 4
) (
   input  logic              CLK,
   input  logic              RST,
   rom_port_arbiter_if.slave bus,
   output logic              rom_en,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_q
);
   localparam int             SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [31:0]    ROM_BYTES  = 32'(ROM_SIZE);

   logic [SW-1:0] starve_cnt;
   logic          i_win;
   logic          d_win;
   logic          i_ok;
   logic          d_ok;
   logic [31:0]   win_addr;
   logic [31:0]   win_off;
   logic [31:0]   load_word;
   owner_e        owner_q;
   owner_e        owner_d;
   rsp_ctx_t      ctx_q;
   rsp_ctx_t      ctx_d;

   assign i_ok = addr_ok(bus.i_addr, SZ_WORD, ROM_START, ROM_BYTES);
   assign d_ok = addr_ok(bus.d_addr, bus.d_size, ROM_START, ROM_BYTES);

   // Data normally wins a collision; fetch wins once it has lost STARVE_LIMIT times running.
   always_comb begin
      i_win = 1'b0;
      d_win = 1'b0;
      if (!RST) begin
         if (bus.i_req && (!bus.d_req || starve_cnt == STARVE_MAX)) begin
            i_win = 1'b1;
         end else if (bus.d_req) begin
            d_win = 1'b1;
         end
      end
   end

   assign bus.i_gnt = i_win;
   assign bus.d_gnt = d_win;

   // Illegal requests are still granted (so they get an error reply) but never read the ROM.
   assign win_addr = d_win ? bus.d_addr : bus.i_addr;
   assign win_off  = win_addr - ROM_START;
   assign rom_addr = ROM_AW'(win_off >> 2);
   assign rom_en   = (i_win & i_ok) | (d_win & d_ok);

   // Count consecutive fetch losses; any cycle fetch is idle or wins restarts the count.
   always_ff @(posedge CLK) begin
      if (RST) begin
         starve_cnt <= '0;
      end else if (!bus.i_req || i_win) begin
         starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Owner register: remembers whose ROM word arrives next cycle and how to shape it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         owner_q <= OWN_NONE;
         ctx_q   <= '0;
      end else begin
         owner_q <= owner_d;
         ctx_q   <= ctx_d;
      end
   end

   // Next owner follows this cycle's grant and drops to NONE when nothing was granted.
   always_comb begin
      owner_d = OWN_NONE;
      ctx_d   = '0;
      if (i_win) begin
         owner_d    = OWN_FETCH;
         ctx_d.err  = ~i_ok;
         ctx_d.off  = bus.i_addr[1:0];
         ctx_d.size = SZ_WORD;
         ctx_d.uns  = 1'b1;
      end else if (d_win) begin
         owner_d    = OWN_DATA;
         ctx_d.err  = ~d_ok;
         ctx_d.off  = bus.d_addr[1:0];
         ctx_d.size = bus.d_size;
         ctx_d.uns  = bus.d_unsigned;
      end
   end

   rom_load_align u_align (
      .rom_q       (rom_q),
      .offset      (ctx_q.off),
      .size        (ctx_q.size),
      .is_unsigned (ctx_q.uns),
      .rdata       (load_word)
   );

   // Steer the response to the owner only; errors and reset force zero data.
   always_comb begin
      bus.i_rvalid = 1'b0;
      bus.i_err    = 1'b0;
      bus.i_rdata  = '0;
      bus.d_rvalid = 1'b0;
      bus.d_err    = 1'b0;
      bus.d_rdata  = '0;
      if (!RST) begin
         case (owner_q)
            OWN_FETCH: begin
               bus.i_rvalid = 1'b1;
               bus.i_err    = ctx_q.err;
               if (!ctx_q.err) bus.i_rdata = rom_q;
            end
            OWN_DATA: begin
               bus.d_rvalid = 1'b1;
               bus.d_err    = ctx_q.err;
               if (!ctx_q.err) bus.d_rdata = load_word;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Randomised scoreboard bench for rom_port_arbiter with a byte-level reference model.
// Latency: expects each granted request to answer exactly one cycle later.
// Backpressure: bench requesters hold a request until the model says it is granted.
`timescale 1ns/1ps
module tb_rom_port_arbiter;
   import rom_arb_pkg::*;

   localparam int          ROM_SIZE     = 20480;
   localparam int          WORDS        = ROM_SIZE / 4;
   localparam int          ROM_AW       = 13;
   localparam int          STARVE_LIMIT = 4;
   localparam logic [31:0] ROM_START    = 32'h0;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              rom_en;
   logic [ROM_AW-1:0] rom_addr;
   logic [31:0]       rom_q = '0;

   rom_port_arbiter_if bus();

   rom_port_arbiter #(
      .ROM_SIZE(ROM_SIZE), .ROM_START(ROM_START), .ROM_AW(ROM_AW), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .CLK(CLK), .RST(RST), .bus(bus), .rom_en(rom_en), .rom_addr(rom_addr), .rom_q(rom_q)
   );

   always #5 CLK = ~CLK;

   // Synchronous ROM: word appears one cycle after the strobe.
   logic [31:0] romw [WORDS];
   always @(posedge CLK) begin
      int idx;
      idx = int'(rom_addr);
      if (rom_en) rom_q <= (idx < WORDS) ? romw[idx] : 32'hBAD0_BAD0;
   end

   typedef struct { int due; logic [31:0] data; logic err; } exp_t;
   exp_t pq[2][$];   // 0 = fetch, 1 = data

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int lost   = 0;   // consecutive fetch losses as seen by the model

   logic        i_pend = 0, d_pend = 0, d_u = 0;
   logic [31:0] i_a = '0, d_a = '0;
   logic [1:0]  d_sz = '0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, req, cyc);
      end
   endtask

   // ---- reference model: byte-addressed view of the ROM ----
   function automatic logic [7:0] ref_byte(input longint off);
      logic [31:0] w;
      w = romw[int'(off / 4)];
      return 8'(w >> (8 * int'(off % 4)));
   endfunction

   function automatic logic ref_valid(input logic [31:0] a, input int sz);
      longint av, lo, hi;
      av = 0; av[31:0] = a;
      lo = 0; lo[31:0] = ROM_START;
      hi = lo + ROM_SIZE - 4;
      if (sz == 3) return 1'b0;
      if (av % (longint'(1) << sz) != 0) return 1'b0;
      return (av >= lo) && (av <= hi);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input int sz, input logic u);
      longint base, v, av, lo;
      int n;
      av = 0; av[31:0] = a;
      lo = 0; lo[31:0] = ROM_START;
      base = av - lo;
      n = 1 << sz;
      v = 0;
      for (int k = 0; k < n; k++) v += longint'(ref_byte(base + k)) << (8 * k);
      if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
      return v[31:0];
   endfunction

   task automatic issue_i(input logic [31:0] a);
      i_pend = 1'b1; i_a = a;
   endtask

   task automatic issue_d(input logic [31:0] a, input logic [1:0] sz, input logic u);
      d_pend = 1'b1; d_a = a; d_sz = sz; d_u = u;
   endtask

   // One bus cycle: drive pending requests, check grant/strobe, push expected responses.
   task automatic step();
      logic ew_i, ew_d, v;
      @(posedge CLK); #1;
      bus.i_req = i_pend; bus.i_addr = i_a;
      bus.d_req = d_pend; bus.d_addr = d_a; bus.d_size = d_sz; bus.d_unsigned = d_u;
      @(negedge CLK);
      ew_i = i_pend && (!d_pend || lost == STARVE_LIMIT);
      ew_d = d_pend && !ew_i;
      chk("i_gnt", 32'(bus.i_gnt), 32'(ew_i));
      chk("d_gnt", 32'(bus.d_gnt), 32'(ew_d));
      if (i_pend && !ew_i) lost = (lost < STARVE_LIMIT) ? lost + 1 : lost;
      else lost = 0;
      if (ew_i) begin
         v = ref_valid(i_a, 2);
         chk("i_rom_en", 32'(rom_en), 32'(v));
         if (v) chk("i_rom_addr", 32'(rom_addr), (i_a - ROM_START) >> 2);
         pq[0].push_back('{due: cyc + 1, data: v ? ref_load(i_a, 2, 1'b1) : 32'h0, err: !v});
         i_pend = 1'b0;
      end else if (ew_d) begin
         v = ref_valid(d_a, int'(d_sz));
         chk("d_rom_en", 32'(rom_en), 32'(v));
         if (v) chk("d_rom_addr", 32'(rom_addr), (d_a - ROM_START) >> 2);
         pq[1].push_back('{due: cyc + 1, data: v ? ref_load(d_a, int'(d_sz), d_u) : 32'h0, err: !v});
         d_pend = 1'b0;
      end else begin
         chk("idle_rom_en", 32'(rom_en), 32'h0);
      end
   endtask

   // One cycle of reset with both ports requesting; in-flight responses are discarded.
   task automatic reset_cycle();
      @(posedge CLK); #1;
      RST = 1'b1;
      pq[0].delete(); pq[1].delete();
      bus.i_req = 1'b1; bus.d_req = 1'b1;
      @(negedge CLK);
      chk("rst_i_gnt", 32'(bus.i_gnt), 32'h0);
      chk("rst_d_gnt", 32'(bus.d_gnt), 32'h0);
      chk("rst_rom_en", 32'(rom_en), 32'h0);
      @(posedge CLK); #1;
      RST = 1'b0;
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      lost = 0;
      @(negedge CLK);
      chk("rst_starve_cnt", 32'(dut.starve_cnt), 32'h0);
      chk("rst_owner", 32'(dut.owner_q), 32'(OWN_NONE));
   endtask

   function automatic logic [31:0] rand_addr(input int sz);
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = ROM_START + $urandom_range(0, ROM_SIZE - 1);
      else if (sel == 7) a = ROM_START + ROM_SIZE - $urandom_range(1, 8);
      else if (sel == 8) a = $urandom;
      else               a = 32'hFFFF_FFFF - $urandom_range(0, 7);
      if (sz < 3 && $urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      return a;
   endfunction

   // Monitor: every cycle each port either delivers the due response or stays silent.
   initial begin
      logic        rv, er;
      logic [31:0] rd;
      exp_t        e;
      @(negedge CLK);
      forever begin
         @(negedge CLK);
         for (int p = 0; p < 2; p++) begin
            rv = (p == 0) ? bus.i_rvalid : bus.d_rvalid;
            er = (p == 0) ? bus.i_err    : bus.d_err;
            rd = (p == 0) ? bus.i_rdata  : bus.d_rdata;
            while (pq[p].size() > 0 && pq[p][0].due < cyc) begin
               e = pq[p].pop_front();
               chk($sformatf("%s_missed_rsp", p == 0 ? "i" : "d"), 32'h0, 32'h1);
            end
            if (pq[p].size() > 0 && pq[p][0].due == cyc) begin
               e = pq[p].pop_front();
               chk($sformatf("%s_rvalid", p == 0 ? "i" : "d"), 32'(rv), 32'h1);
               chk($sformatf("%s_err", p == 0 ? "i" : "d"), 32'(er), 32'(e.err));
               chk($sformatf("%s_rdata", p == 0 ? "i" : "d"), rd, e.data);
            end else begin
               chk($sformatf("%s_idle_rsp", p == 0 ? "i" : "d"), {rv, er, 30'h0} | rd, 32'h0);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < WORDS; i++) romw[i] = $urandom;
      romw[0] = 32'h80FF_7F01;
      romw[4] = 32'hDEAD_BEEF;
      bus.i_req = 1'b1; bus.i_addr = 32'h10;
      bus.d_req = 1'b1; bus.d_addr = 32'h0; bus.d_size = SZ_WORD; bus.d_unsigned = 1'b0;

      // Reset: grants and strobe forced low even with both ports requesting.
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("por_i_gnt", 32'(bus.i_gnt), 32'h0);
      chk("por_d_gnt", 32'(bus.d_gnt), 32'h0);
      chk("por_rom_en", 32'(rom_en), 32'h0);
      @(posedge CLK); #1;
      RST = 1'b0; bus.i_req = 1'b0; bus.d_req = 1'b0;
      @(negedge CLK);
      chk("por_starve_cnt", 32'(dut.starve_cnt), 32'h0);
      chk("por_owner", 32'(dut.owner_q), 32'(OWN_NONE));

      // Fetch alone, then the three extraction cases on word 0.
      issue_i(32'h10);          step();
      issue_d(32'h3, SZ_BYTE, 1'b0); step();
      issue_d(32'h2, SZ_HALF, 1'b1); step();
      issue_d(32'h1, SZ_BYTE, 1'b0); step();
      step();

      // Continuous contention: data wins four times, then fetch gets one.
      for (int k = 0; k < 15; k++) begin
         if (!i_pend) issue_i(32'(4 * k));
         if (!d_pend) issue_d(32'(4 * (100 + k)), SZ_WORD, 1'b0);
         step();
      end
      i_pend = 1'b0; d_pend = 1'b0;
      step();

      // Boundary and error requests.
      issue_d(32'(ROM_SIZE), SZ_WORD, 1'b0);      step();
      issue_d(32'h2, SZ_WORD, 1'b0);              step();
      issue_d(32'h40, 2'd3, 1'b0);                step();
      issue_i(32'hFFFF_FFFC);                     step();
      issue_d(32'(ROM_SIZE - 4), SZ_WORD, 1'b0);  step();
      issue_d(32'(ROM_SIZE - 2), SZ_HALF, 1'b1);  step();
      issue_i(32'(ROM_SIZE - 4));                 step();
      step();

      // Reset the cycle after a fetch grant: its response must never appear.
      issue_i(32'h20); step();
      reset_cycle();

      // Build up fetch starvation, reset, and confirm the count restarted from zero.
      for (int k = 0; k < 3; k++) begin
         if (!i_pend) issue_i(32'(8 * k));
         if (!d_pend) issue_d(32'(4 * (200 + k)), SZ_HALF, 1'b0);
         step();
      end
      reset_cycle();
      for (int k = 0; k < 10; k++) begin
         if (!i_pend) issue_i(32'(4 * (300 + k)));
         if (!d_pend) issue_d(32'(4 * (400 + k) + 1), SZ_BYTE, 1'b1);
         step();
      end
      i_pend = 1'b0; d_pend = 1'b0;
      step();

      // Randomised traffic over legal, boundary and wrapping addresses.
      for (int n = 0; n < 3000; n++) begin
         if (!i_pend && $urandom_range(0, 3) != 0) issue_i(rand_addr(2));
         if (!d_pend && $urandom_range(0, 3) != 0) begin
            int sz;
            sz = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            issue_d(rand_addr(sz), 2'(sz), 1'($urandom_range(0, 1)));
         end
         step();
      end
      i_pend = 1'b0; d_pend = 1'b0;
      repeat (3) step();
      chk("i_queue_drained", 32'(pq[0].size()), 32'h0);
      chk("d_queue_drained", 32'(pq[1].size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Shares the single-port synchronous instruction ROM between the core's instruction-fetch port and its data-load port. Grants at most one read per cycle, drives the ROM word address, and routes the one-cycle-late ROM word back to the winning port. Data-port responses get byte/half/word extraction with sign or zero extension. Out-of-range and misaligned requests get an error response without touching the ROM.

## Interface
- ROM_SIZE, 20480, ROM size in bytes (multiple of 4)
- ROM_START, 32'h0, byte base address of ROM
- ROM_AW, 13, ROM word-address width; must satisfy 2^ROM_AW ≥ ROM_SIZE/4
- STARVE_LIMIT, 4, consecutive lost cycles after which fetch beats data
---
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous active-high reset
- i_req  in  1  fetch request
- i_addr  in  32  fetch byte address (always a word read)
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  fetch response valid
- i_rdata  out  32  fetch word
- i_err  out  1  fetch error, qualified by i_rvalid
- d_req  in  1  load request
- d_addr  in  32  load byte address
- d_size  in  2  0 byte, 1 half, 2 word (3 is an error)
- d_unsigned  in  1  zero-extend when 1, sign-extend when 0
- d_gnt, d_rvalid, d_rdata[31:0], d_err  out  —  same meaning as fetch
- rom_en  out  1  ROM read strobe
- rom_addr  out  ROM_AW  ROM word address, (addr−ROM_START)>>2
- rom_q  in  32  ROM data, valid one cycle after rom_en

## Operation
- Request valid: ROM_START ≤ addr ≤ ROM_START+ROM_SIZE−4 and aligned (word: addr[1:0]=0; half: addr[0]=0; byte: any). Otherwise it is an error request.
- Arbitration is combinational each cycle:
  - Only one port requests: that port wins.
  - Both request: data wins, unless starve_cnt = STARVE_LIMIT, in which case fetch wins.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - +1 when fetch requests and loses, saturating.
  - Cleared when fetch wins or i_req is low.
- The winner's x_gnt is high in the same cycle. The loser's gnt is low, and the requester holds its request.
- rom_en = 1 only when the winner's request is valid. Error requests are granted but do not strobe the ROM.
- Response owner register states: NONE, FETCH, DATA.
  - Loaded at grant with owner, err, addr[1:0], d_size, d_unsigned.
  - Goes to NONE when there is no grant.
- Response cycle (the cycle after grant):
  - Owner's rvalid = 1.
  - Error: err = 1 and rdata = 0.
  - Otherwise, fetch: rdata = rom_q.
  - Otherwise, data: lane = rom_q >> (8·offset), little-endian. Byte takes lane[7:0] and half takes lane[15:0], then sign- or zero-extend to 32 bits. Word passes through.
- Non-owner rvalid and err = 0, rdata = 0.

## Timing
- Grant cycle N → response at N+1. This is also the ROM read latency, so the arbiter never stalls.
- Throughput: one read per cycle total. Back-to-back grants to alternating ports are allowed.
- Reset values:
  - Owner = NONE, starve_cnt = 0.
  - All rvalid/err = 0, rdata = 0.
  - gnt and rom_en are forced to 0 while RST = 1.
- Reset mid-operation: a grant made in the cycle before RST rises produces no response. rvalid stays 0 in the reset cycle and the cycle after it.
- Address at the last word, ROM_START+ROM_SIZE−4: valid. At ROM_START+ROM_SIZE−2 as a half: error (range check is on the word base).
- Address below ROM_START: error; wrap-around in the subtraction must not alias into range.
- d_size = 3: error regardless of address.

## Structure
- Package rom_arb_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - owner encodings OWN_NONE/OWN_FETCH/OWN_DATA;
  - function addr_ok(addr, size) parameterised by ROM_START/ROM_SIZE.
- One sub-module, rom_load_align: combinational (rom_q, offset, size, unsigned) → rdata.
- Arbiter, starve counter and owner register stay in the top module.

## Test plan
- Fetch alone, i_addr=0x10, rom word 4 = 0xDEADBEEF → i_gnt in the same cycle, next cycle i_rvalid=1, i_rdata=0xDEADBEEF, rom_addr=4.
- Word 0 = 0x80FF7F01:
  - d_addr=0x3, byte, signed → 0xFFFFFF80.
  - d_addr=0x2, half, unsigned → 0x000080FF.
  - d_addr=0x1, byte, signed → 0x0000007F.
- Both ports request continuously → pattern D,D,D,D,I repeating with STARVE_LIMIT=4; no response is lost and each rvalid matches its own address.
- Out-of-range/misaligned requests → gnt=1, rom_en=0, next cycle err=1, rdata=0:
  - d_addr=ROM_SIZE (word);
  - d_addr=0x2 (word);
  - d_size=3;
  - i_addr=0xFFFFFFFC.
- RST asserted the cycle after a fetch grant → no i_rvalid in that cycle or the next; starve_cnt=0 and owner=NONE afterwards.
